conv1d_aip_core: RTL and testbench

- Bus-attached 1-D discrete convolution accelerator with an AIP-style register/memory interface.
- Host loads vector X (≤31 words) and vector Y (≤31 words), writes sizes, pulses start.
- Core computes Z = X * Y (length sizeX+sizeY-1), raises done and the active-low interrupt; host then reads Z by burst.

---
 rtl/conv1d_aip_core.sv | 225 ++++++++++++++++++++++
 tb/tb_conv1d_aip_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_aip_core.sv
// Bus-attached 1-D convolution accelerator: host loads X/Y and sizes, pulses start,
// and the core computes Z = X * Y one multiply-accumulate term per cycle.
module conv1d_aip_core #(
    parameter int                DATAWIDTH   = 32,
    parameter int                MEMX_DEPTH  = 32,
    parameter int                MEMY_DEPTH  = 32,
    parameter int                MEMZ_DEPTH  = 64,
    parameter logic [DATAWIDTH-1:0] IP_ID_VALUE = 32'h1000500A
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en_s,
    input  logic [DATAWIDTH-1:0] data_in,
    output logic [DATAWIDTH-1:0] data_out,
    input  logic                 write,
    input  logic                 read,
    input  logic                 start,
    input  logic [4:0]           conf_dbus,
    output logic                 int_req
);
    localparam int XAW = $clog2(MEMX_DEPTH);
    localparam int YAW = $clog2(MEMY_DEPTH);
    localparam int ZAW = $clog2(MEMZ_DEPTH);
    localparam int SW  = 5;

    localparam logic [4:0] C_MX = 5'd0;
    localparam logic [4:0] C_AX = 5'd1;
    localparam logic [4:0] C_MY = 5'd2;
    localparam logic [4:0] C_AY = 5'd3;
    localparam logic [4:0] C_MZ = 5'd4;
    localparam logic [4:0] C_AZ = 5'd5;
    localparam logic [4:0] C_DC = 5'd6;
    localparam logic [4:0] C_ST = 5'd30;
    localparam logic [4:0] C_ID = 5'd31;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAC, S_STORE, S_DONE} state_t;

    logic [DATAWIDTH-1:0] mem_x [MEMX_DEPTH];
    logic [DATAWIDTH-1:0] mem_y [MEMY_DEPTH];
    logic [DATAWIDTH-1:0] mem_z [MEMZ_DEPTH];

    state_t               state_q, state_d;
    logic [XAW-1:0]       ptr_x_q, ptr_x_d;
    logic [YAW-1:0]       ptr_y_q, ptr_y_d;
    logic [ZAW-1:0]       ptr_z_q, ptr_z_d;
    logic [DATAWIDTH-1:0] dconfig_q, dconfig_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [7:0]           mask_q, mask_d;
    logic [ZAW-1:0]       n_q, n_d;
    logic [SW-1:0]        k_q, k_d;
    logic [DATAWIDTH-1:0] acc_q, acc_d;
    logic                 int_req_q;

    logic                 x_we_s, y_we_s, z_we_s;
    logic [SW-1:0]        size_x_s, size_y_s;
    logic [ZAW-1:0]       n_last_s;
    logic [ZAW:0]         diff_s;
    logic                 y_ok_s;
    logic [DATAWIDTH-1:0] prod_s;
    logic [DATAWIDTH-1:0] status_s;

    assign size_x_s = dconfig_q[4:0];
    assign size_y_s = dconfig_q[9:5];
    assign n_last_s = ZAW'(size_x_s) + ZAW'(size_y_s) - ZAW'(2);
    // n-k as a signed quantity: top bit flags a negative Y index
    assign diff_s   = {1'b0, n_q} - (ZAW + 1)'(k_q);
    assign y_ok_s   = ~diff_s[ZAW] && (diff_s[ZAW-1:0] < ZAW'(size_y_s));
    assign prod_s   = mem_x[k_q[XAW-1:0]] * mem_y[diff_s[YAW-1:0]];
    assign status_s = {8'h00, mask_q, 14'h0000, busy_q, done_q};
    assign int_req  = int_req_q;

    // Host read mux, purely combinational from the select code
    always_comb begin
        data_out = '0;
        case (conf_dbus)
            C_MX:    data_out = mem_x[ptr_x_q];
            C_MY:    data_out = mem_y[ptr_y_q];
            C_MZ:    data_out = mem_z[ptr_z_q];
            C_DC:    data_out = dconfig_q;
            C_ST:    data_out = status_s;
            C_ID:    data_out = IP_ID_VALUE;
            default: data_out = '0;
        endcase
    end

    // Bus decode, sticky flags and compute FSM next-state
    always_comb begin
        state_d   = state_q;
        ptr_x_d   = ptr_x_q;
        ptr_y_d   = ptr_y_q;
        ptr_z_d   = ptr_z_q;
        dconfig_d = dconfig_q;
        done_d    = done_q;
        busy_d    = busy_q;
        mask_d    = mask_q;
        n_d       = n_q;
        k_d       = k_q;
        acc_d     = acc_q;
        x_we_s    = 1'b0;
        y_we_s    = 1'b0;
        z_we_s    = 1'b0;
        if (en_s) begin
            if (read && (conf_dbus == C_MZ)) begin
                ptr_z_d = ptr_z_q + ZAW'(1);
            end else begin
                ptr_z_d = ptr_z_q;
            end
            if (write) begin
                case (conf_dbus)
                    C_MX: begin
                        x_we_s  = 1'b1;
                        ptr_x_d = ptr_x_q + XAW'(1);
                    end
                    C_AX: ptr_x_d = data_in[XAW-1:0];
                    C_MY: begin
                        y_we_s  = 1'b1;
                        ptr_y_d = ptr_y_q + YAW'(1);
                    end
                    C_AY: ptr_y_d = data_in[YAW-1:0];
                    C_AZ: ptr_z_d = data_in[ZAW-1:0];
                    C_DC: dconfig_d = data_in;
                    C_ST: begin
                        mask_d = data_in[23:16];
                        done_d = done_q & ~data_in[0];
                    end
                    default: x_we_s = 1'b0;
                endcase
            end else begin
                x_we_s = 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        n_d     = '0;
                        state_d = ((size_x_s == 5'd0) || (size_y_s == 5'd0)) ? S_DONE : S_INIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_INIT: begin
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
                S_MAC: begin
                    if (y_ok_s) begin
                        acc_d = acc_q + prod_s;
                    end else begin
                        acc_d = acc_q;
                    end
                    k_d = k_q + SW'(1);
                    if (k_q == (size_x_s - 5'd1)) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_MAC;
                    end
                end
                S_STORE: begin
                    z_we_s = 1'b1;
                    if (n_q == n_last_s) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + ZAW'(1);
                        state_d = S_INIT;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q   <= S_IDLE;
            ptr_x_q   <= '0;
            ptr_y_q   <= '0;
            ptr_z_q   <= '0;
            dconfig_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            mask_q    <= 8'h00;
            n_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            int_req_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_x_q   <= ptr_x_d;
            ptr_y_q   <= ptr_y_d;
            ptr_z_q   <= ptr_z_d;
            dconfig_q <= dconfig_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            mask_q    <= mask_d;
            n_q       <= n_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            int_req_q <= ~(done_d & mask_d[0]);
        end
    end

    // Vector memories; contents survive reset
    always_ff @(posedge clk) begin
        if (x_we_s) begin
            mem_x[ptr_x_q] <= data_in;
        end
        if (y_we_s) begin
            mem_y[ptr_y_q] <= data_in;
        end
        if (z_we_s) begin
            mem_z[n_q] <= acc_q;
        end
    end
endmodule

// File: tb/tb_conv1d_aip_core.sv
// Self-checking bench for conv1d_aip_core: register vector table plus
// randomized convolutions compared against a direct-sum reference model.
module tb_conv1d_aip_core;
    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        en_s = 1'b1;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  conf_dbus = 5'd0;
    logic        int_req;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] xv[$];
    logic [31:0] yv[$];
    logic [31:0] zexp[64];

    typedef struct {
        logic        do_wr;
        logic [4:0]  wcode;
        logic [31:0] wdata;
        logic [4:0]  rcode;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];

    conv1d_aip_core dut (
        .clk(clk), .rst_a(rst_a), .en_s(en_s), .data_in(data_in), .data_out(data_out),
        .write(write), .read(read), .start(start), .conf_dbus(conf_dbus), .int_req(int_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input logic [4:0] code, input logic [31:0] d);
        @(negedge clk);
        conf_dbus = code; data_in = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] code, output logic [31:0] v);
        @(negedge clk);
        conf_dbus = code;
        #1 v = data_out;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load();
        wr(5'd1, 32'd0);
        foreach (xv[i]) wr(5'd0, xv[i]);
        wr(5'd3, 32'd0);
        foreach (yv[i]) wr(5'd2, yv[i]);
        wr(5'd6, (32'(yv.size()) << 5) | 32'(xv.size()));
    endtask

    task automatic model();
        int n = xv.size() + yv.size() - 1;
        for (int i = 0; i < n; i++) zexp[i] = 32'd0;
        for (int i = 0; i < xv.size(); i++)
            for (int j = 0; j < yv.size(); j++)
                zexp[i + j] = zexp[i + j] + xv[i] * yv[j];
    endtask

    // start, then poll STATUS.done with a bounded wait; latency counts the start edge as cycle 1
    task automatic go(input string name, input int bound);
        int lat = 1;
        pulse_start();
        conf_dbus = 5'd30;
        #1;
        while (!data_out[0] && lat < 5000) begin
            @(negedge clk);
            conf_dbus = 5'd30;
            #1 lat++;
        end
        chk({name, "_done"}, {31'd0, data_out[0]}, 32'd1);
        chk({name, "_latency_ok"}, {31'd0, lat <= bound}, 32'd1);
    endtask

    task automatic burst(input string name, input int off, input int cnt);
        wr(5'd5, 32'(off));
        conf_dbus = 5'd4; read = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            #1 chk($sformatf("%s_z%0d", name, off + i), data_out, zexp[off + i]);
            @(negedge clk);
        end
        read = 1'b0;
    endtask

    function automatic int lat_bound();
        return (xv.size() + yv.size() - 1) * (xv.size() + 2) + 3;
    endfunction

    initial begin
        logic [31:0] v;
        tbl[0]  = '{1'b0, 5'd0,  32'h0,        5'd31, 32'h1000500A};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        5'd30, 32'h00000000};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        5'd6,  32'h00000000};
        tbl[3]  = '{1'b1, 5'd30, 32'h00010000, 5'd30, 32'h00010000};
        tbl[4]  = '{1'b1, 5'd6,  32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF};
        tbl[5]  = '{1'b1, 5'd6,  32'h00000000, 5'd6,  32'h00000000};
        tbl[6]  = '{1'b1, 5'd1,  32'h00000025, 5'd12, 32'h00000000};
        tbl[7]  = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd7,  32'h00000000};
        tbl[8]  = '{1'b1, 5'd1,  32'h00000005, 5'd0,  32'hDEADBEEF};
        tbl[9]  = '{1'b1, 5'd7,  32'h000003FF, 5'd6,  32'h00000000};
        tbl[10] = '{1'b1, 5'd25, 32'hFFFFFFFF, 5'd25, 32'h00000000};
        tbl[11] = '{1'b1, 5'd4,  32'h00000123, 5'd30, 32'h00010000};

        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        #1 chk("reset_int_req", {31'd0, int_req}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_wr) wr(tbl[i].wcode, tbl[i].wdata);
            rd(tbl[i].rcode, v);
            chk($sformatf("tbl%0d", i), v, tbl[i].exp);
        end

        // basic run with interrupt enabled
        xv = '{32'd1, 32'd2, 32'd3};
        yv = '{32'd1, 32'd1};
        load();
        model();
        go("basic", lat_bound());
        chk("basic_int_req", {31'd0, int_req}, 32'd0);
        rd(5'd30, v);
        chk("basic_status", v, 32'h00010001);
        burst("basic", 0, 4);

        wr(5'd30, 32'h00010001);
        chk("clear_int_req", {31'd0, int_req}, 32'd1);
        rd(5'd30, v);
        chk("clear_status", v, 32'h00010000);

        // masked run with random 5x10 vectors
        wr(5'd30, 32'h00000000);
        xv.delete(); yv.delete();
        for (int i = 0; i < 5; i++) xv.push_back($urandom_range(0, 99));
        for (int i = 0; i < 10; i++) yv.push_back($urandom_range(0, 99));
        load();
        model();
        go("r5x10", lat_bound());
        chk("masked_int_req", {31'd0, int_req}, 32'd1);
        burst("r5x10", 0, 14);
        burst("r5x10_off3", 3, 4);

        for (int t = 0; t < 3; t++) begin
            int sx = (t == 0) ? 31 : $urandom_range(1, 31);
            int sy = (t == 0) ? 31 : $urandom_range(1, 31);
            xv.delete(); yv.delete();
            for (int i = 0; i < sx; i++) xv.push_back($urandom);
            for (int i = 0; i < sy; i++) yv.push_back($urandom);
            load();
            model();
            go($sformatf("rnd%0d", t), lat_bound());
            burst($sformatf("rnd%0d", t), 0, sx + sy - 1);
        end

        xv = '{32'hFFFFFFFF};
        yv = '{32'd2};
        load();
        model();
        go("ovf", lat_bound());
        burst("ovf", 0, 1);
        chk("ovf_model", zexp[0], 32'hFFFFFFFE);

        wr(5'd6, 32'd0);
        go("zero", 3);
        burst("zero_unchanged", 0, 8);

        // enable low: writes and start must not land
        en_s = 1'b0;
        wr(5'd30, 32'h00FF0001);
        wr(5'd6, 32'h00000021);
        pulse_start();
        en_s = 1'b1;
        rd(5'd30, v);
        chk("hold_status", v, 32'h00000001);
        rd(5'd6, v);
        chk("hold_dconfig", v, 32'h00000000);
        repeat (3) @(negedge clk);
        rd(5'd30, v);
        chk("hold_idle", v, 32'h00000001);

        // reset in the middle of a long run
        wr(5'd30, 32'h00010001);
        xv.delete(); yv.delete();
        for (int i = 0; i < 31; i++) xv.push_back($urandom);
        for (int i = 0; i < 31; i++) yv.push_back($urandom);
        load();
        pulse_start();
        repeat (40) @(negedge clk);
        conf_dbus = 5'd30;
        #1 chk("mid_busy", data_out, 32'h00010002);
        rst_a = 1'b0;
        #1 chk("rst_status", data_out, 32'h00000000);
        chk("rst_int_req", {31'd0, int_req}, 32'd1);
        @(negedge clk);
        rst_a = 1'b1;
        rd(5'd6, v);
        chk("rst_dconfig", v, 32'h00000000);

        xv.delete(); yv.delete();
        for (int i = 0; i < 4; i++) xv.push_back($urandom);
        for (int i = 0; i < 6; i++) yv.push_back($urandom);
        wr(5'd30, 32'h00010000);
        load();
        model();
        go("after_rst", lat_bound());
        chk("after_rst_int_req", {31'd0, int_req}, 32'd0);
        burst("after_rst", 0, 9);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
